// File: rtl/piso8_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial converter.
// Build option: define PISO8_PARITY_EN to add a ninth, even-parity beat to each frame.
package piso8_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int GAP_W  = 4;

`ifdef PISO8_PARITY_EN
    // Eight data beats plus one parity beat, so the counter needs a fourth bit
    localparam int BEATS = 9;
    localparam int CNT_W = 4;
`else
    localparam int BEATS = 8;
    localparam int CNT_W = 3;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Map a beat number to the mux select for the chosen bit order
    function automatic logic [SEL_W-1:0] beat_sel(input logic [SEL_W-1:0] beat,
                                                  input logic             lsb_first);
        return lsb_first ? beat : (SEL_W'(DATA_W - 1) - beat);
    endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 bit multiplexer: y = d[sel].
module mux8 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = d[sel];

endmodule

// File: rtl/piso8_serializer.sv
// 8-bit parallel-in / serial-out converter with valid/ready on both sides.
// A word is latched in IDLE, shifted out one bit per accepted beat in SHIFT,
// then IDLE_GAP quiet cycles are spent in GAP before the next word is taken.
// Build option: define PISO8_PARITY_EN to append an even-parity beat (^word)
// after the eight data bits; out_last then marks only the parity beat.
module piso8_serializer
    import piso8_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int IDLE_GAP  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam bit               HAS_GAP  = (IDLE_GAP > 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [DATA_W-1:0] d_reg, d_next;

    logic [SEL_W-1:0]  sel;
    logic              mux_bit;
    logic              data_bit;
    logic              accept;
    logic              beat_acc;
    logic              last_beat;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == SHIFT);
    assign busy      = (state_reg != IDLE);

    assign accept    = in_valid && in_ready;
    assign beat_acc  = out_valid && out_ready;
    assign last_beat = (cnt_reg == LAST_CNT);

    // Select comes purely from the beat counter, so it holds under backpressure
    assign sel = beat_sel(cnt_reg[SEL_W-1:0], LSB_FIRST);

    mux8 u_mux8 (
        .d   (d_reg),
        .sel (sel),
        .y   (mux_bit)
    );

`ifdef PISO8_PARITY_EN
    // Beat 8 (counter MSB set) carries the even parity of the held word
    assign data_bit = cnt_reg[CNT_W-1] ? (^d_reg) : mux_bit;
`else
    assign data_bit = mux_bit;
`endif

    // Frame outputs are forced low outside SHIFT so nothing stale leaks out
    assign out_bit   = out_valid && data_bit;
    assign out_first = out_valid && (cnt_reg == '0);
    assign out_last  = out_valid && last_beat;

    // Next-state logic for the IDLE -> SHIFT -> (GAP) -> IDLE sequence
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        d_next       = d_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    d_next     = in_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (beat_acc) begin
                    if (last_beat) begin
                        cnt_next = '0;
                        if (HAS_GAP) begin
                            gap_cnt_next = '0;
                            state_next   = GAP;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gap_cnt_reg <= '0;
            d_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            d_reg       <= d_next;
        end
    end

endmodule

// File: doc/piso8_serializer.md
Name: piso8_serializer

Overview:
- Upstream stage for the 8:1 mux `mux8`: accepts an 8-bit parallel word over a valid/ready handshake and holds it as the mux `D`.
- Steps the mux `sel` 0..7 with an internal counter and emits the word one bit per accepted beat on a serial valid/ready stream.
- Also emits frame markers (`out_first`, `out_last`) and `busy`.
- Used wherever the team needs parallel-to-serial conversion, e.g. a serial LED/shift-register driver.

Parameters:
- LSB_FIRST, 1: 1 = `sel` counts 0→7 (D[0] first); 0 = `sel` counts 7→0 (D[7] first).
- IDLE_GAP, 0: number of idle cycles, 0..15, inserted after each frame before the next word is accepted.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  8  parallel word
- out_valid  output  1  `out_bit` valid
- out_ready  input  1  downstream accepts the current bit
- out_bit  output  1  serial data = mux8(D_reg, sel)
- out_first  output  1  current bit is bit 0 of the frame
- out_last  output  1  current bit is the final bit of the frame
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (async, immediate):
  - state=IDLE, cnt=0, gap_cnt=0, D_reg=8'h00.
  - out_valid=0, out_bit=0, out_first=0, out_last=0, busy=0.
  - in_ready=1 once reset is released, because it is decoded from state==IDLE.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid&&in_ready: latch in_data into D_reg, cnt=0, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=1.
    - sel = LSB_FIRST ? cnt : 7-cnt.
    - out_bit = D_reg[sel], combinational from registers only.
    - out_first = (cnt==0).
    - On out_valid&&out_ready: cnt++.
    - On the last beat accepted: go to GAP if IDLE_GAP>0, else IDLE.
  - GAP: in_ready=0, out_valid=0.
    - gap_cnt counts 0..IDLE_GAP-1, then go to IDLE.
- Latency: first bit is valid the cycle after the accepting edge.
- Throughput: minimum frame period is 9+IDLE_GAP cycles with out_ready held at 1.
- Backpressure: while out_valid&&!out_ready, `out_bit`, `out_first`, `out_last` and `sel` hold stable. No bit is ever dropped or repeated.
- No overlap:
  - A new word is never accepted in the same cycle as the last bit.
  - in_valid during SHIFT/GAP is ignored; upstream must hold it.
  - in_data changes during SHIFT do not affect output (D_reg is isolated).
- Counter wrap: cnt is 3 bits (4 with parity); it is cleared on accept and never wraps during a frame.
- Reset mid-frame: frame is aborted, outputs drop immediately, no partial-frame resume.
- IDLE_GAP=0: GAP state is unreachable.

Optional Feature:
- Macro: PISO8_PARITY_EN.
- Defined:
  - A 9th beat carries the even parity bit (^D_reg) after the eight data bits.
  - out_last asserts on the parity beat only; cnt widens to 4 bits and counts 0..8.
  - Minimum frame period becomes 10+IDLE_GAP cycles.
- Undefined: 8 beats per frame, out_last on data beat cnt==7, no parity logic synthesised.

Decomposition:
- Package piso8_pkg:
  - state enum {IDLE, SHIFT, GAP} (2 bits).
  - localparams DATA_W=8, SEL_W=3, and BEATS (8 or 9 depending on PISO8_PARITY_EN).
- Sub-module: instantiate the existing `mux8` (D=D_reg, sel, Y→data bit) for bit selection rather than re-coding the mux.
- Parity bit and framing muxing stay in the top.

Test Plan:
- Reset, LSB_FIRST=1, IDLE_GAP=0: send 8'b01101001 with out_ready=1 → out_bit sequence 1,0,0,1,0,1,1,0 on 8 consecutive cycles; out_first on beat 0, out_last on beat 7; in_ready high again the next cycle.
- LSB_FIRST=0, same word → sequence 0,1,1,0,1,0,0,1; `sel` observed 7..0.
- Backpressure: drop out_ready for 3 cycles at beat 3 → out_bit=1 held stable for 3 cycles, total 11 cycles, sequence unchanged. Changing in_data mid-frame has no effect.
- Back-to-back words 8'hA5 then 8'h3C with IDLE_GAP=2 → second word accepted exactly 2 idle cycles after the last beat; in_ready=0 during SHIFT and GAP.
- Assert rst at beat 4 → out_valid, busy, out_bit go 0 asynchronously; after release, a new word 8'hFF serialises from beat 0.
- With PISO8_PARITY_EN, word 8'b01101001 → 9 beats, 9th = 0 (even parity, popcount 4), out_last only on the 9th. Word 8'h01 → 9th beat = 1.
